// File: rtl/rd_cdc_pkg.sv
// -----------------------------------------------------------------------------
// rd_cdc_pkg
// Shared definitions for the readout toggle-handshake CDC transmitter:
//   - rd_cdc_state_e          : transmitter FSM states (IDLE, WAIT_ACK)
//   - RD_CDC_MIN_SYNC_STAGES  : smallest legal acknowledge synchronizer depth
// -----------------------------------------------------------------------------
package rd_cdc_pkg;

    localparam int unsigned RD_CDC_MIN_SYNC_STAGES = 32'd3;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } rd_cdc_state_e;

endpackage : rd_cdc_pkg

// File: rtl/rd_cdc_tx_if.sv
// -----------------------------------------------------------------------------
// rd_cdc_tx_if
// Bundles the word handshake and the cross-domain toggle signals of rd_cdc_tx.
//   DATA_IN/VALID_IN/READY_OUT : upstream valid/ready word handshake
//   XFER_DATA/XFER_REQ         : held word and request toggle to the far domain
//   XFER_ACK_ASYNC             : acknowledge toggle from the far domain
//   DONE/TIMEOUT_ERR           : completion pulse and sticky timeout flag
// Modports: slave = the transmitter, master = its environment.
// -----------------------------------------------------------------------------
interface rd_cdc_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  VALID_IN;
    logic                  READY_OUT;
    logic [DATA_WIDTH-1:0] XFER_DATA;
    logic                  XFER_REQ;
    logic                  XFER_ACK_ASYNC;
    logic                  DONE;
    logic                  TIMEOUT_ERR;

    modport slave (
        input  DATA_IN, VALID_IN, XFER_ACK_ASYNC,
        output READY_OUT, XFER_DATA, XFER_REQ, DONE, TIMEOUT_ERR
    );

    modport master (
        output DATA_IN, VALID_IN, XFER_ACK_ASYNC,
        input  READY_OUT, XFER_DATA, XFER_REQ, DONE, TIMEOUT_ERR
    );
endinterface : rd_cdc_tx_if

// File: rtl/rd_sync_ar.sv
// -----------------------------------------------------------------------------
// rd_sync_ar
// Single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset
//   i_d   : asynchronous input bit
//   o_q   : synchronized output (last stage)
// -----------------------------------------------------------------------------
module rd_sync_ar #(
    parameter int SYNC_STAGES = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    // Keep the chain as discrete flops placed close together.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous bit through the synchronizer chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule : rd_sync_ar

// File: rtl/rd_cdc_tx.sv
// -----------------------------------------------------------------------------
// rd_cdc_tx
// Source side of a toggle-based word transfer into another clock domain.
// A word accepted on VALID_IN && READY_OUT is held on XFER_DATA while
// XFER_REQ toggles; the block waits until the re-synchronized acknowledge
// toggle equals XFER_REQ, pulses DONE and accepts the next word.
//   CLK, RST : source clock, asynchronous active-high reset
//   bus      : rd_cdc_tx_if.slave (handshake, XFER_*, DONE, TIMEOUT_ERR)
// Optional feature macro: RD_CDC_TX_TIMEOUT_EN enables the sticky acknowledge
// timeout (TIMEOUT_ERR); without it TIMEOUT_ERR is constant 0.
// -----------------------------------------------------------------------------
module rd_cdc_tx
    import rd_cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    rd_cdc_tx_if.slave  bus
);

    if (SYNC_STAGES < RD_CDC_MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $error("rd_cdc_tx: SYNC_STAGES must be at least 3");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rd_cdc_tx: TIMEOUT_CYCLES must be at least 2");
    end

    rd_cdc_state_e         r_state;
    rd_cdc_state_e         w_next_state;
    logic                  w_capture;
    logic                  w_complete;
    logic                  w_ack_sync;
    logic                  r_xfer_req;
    logic [DATA_WIDTH-1:0] r_xfer_data;
    logic                  r_done;

    rd_sync_ar #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (bus.XFER_ACK_ASYNC),
        .o_q   (w_ack_sync)
    );

    // Next-state decode; completion compares toggle levels so a missed
    // intermediate acknowledge value can never strand the FSM.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.VALID_IN) begin
                    w_capture    = 1'b1;
                    w_next_state = WAIT_ACK;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT_ACK: begin
                if (w_ack_sync == r_xfer_req) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT_ACK;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Word/request capture and completion pulse; data only moves on the
    // same edge that toggles the request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_xfer_req  <= 1'b0;
            r_xfer_data <= {DATA_WIDTH{1'b0}};
            r_done      <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_capture) begin
                r_xfer_data <= bus.DATA_IN;
                r_xfer_req  <= ~r_xfer_req;
            end
        end
    end

    assign bus.READY_OUT = (r_state == IDLE);
    assign bus.XFER_REQ  = r_xfer_req;
    assign bus.XFER_DATA = r_xfer_data;
    assign bus.DONE      = r_done;

`ifdef RD_CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout_err;

    // Saturating wait counter and sticky error flag; the FSM keeps waiting
    // so the held word is never dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_to_cnt      <= {CNT_W{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_to_cnt <= {CNT_W{1'b0}};
            end else if ((r_state == WAIT_ACK) && (r_to_cnt != CNT_MAX)) begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end
            if ((r_state == WAIT_ACK) && (r_to_cnt == CNT_MAX)) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.TIMEOUT_ERR = r_timeout_err;
`else
    assign bus.TIMEOUT_ERR = 1'b0;
`endif

endmodule : rd_cdc_tx

// File: tb/tb_rd_cdc_tx.sv
// -----------------------------------------------------------------------------
// tb_rd_cdc_tx
// Self-checking bench for rd_cdc_tx: directed handshake/timing cases with a
// manually driven acknowledge, then 1000 random words acknowledged by a
// destination model running on an unrelated ~37 MHz clock.
// -----------------------------------------------------------------------------
module tb_rd_cdc_tx;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          dclk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          man_ack = 1'b0;
    logic          auto_ack = 1'b0;
    logic          dest_ack = 1'b0;
    logic [2:0]    d_sync = 3'b000;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] sent_q[$];

    rd_cdc_tx_if #(.DATA_WIDTH(DW)) bus ();

    assign bus.DATA_IN        = data_in;
    assign bus.VALID_IN       = valid_in;
    assign bus.XFER_ACK_ASYNC = auto_ack ? dest_ack : man_ack;

    rd_cdc_tx #(
        .DATA_WIDTH     (DW),
        .SYNC_STAGES    (3),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;                       // 100 MHz source clock
    always begin                                // ~37 MHz destination clock
        #13 dclk = ~dclk;
        #14 dclk = ~dclk;
    end

    // Destination model: synchronize the request, take the word on each new
    // request toggle and echo the toggle back as the acknowledge.
    always @(posedge dclk) begin
        d_sync <= {d_sync[1:0], bus.XFER_REQ};
        if (!auto_ack) begin
            dest_ack <= man_ack;
        end else if (d_sync[2] != dest_ack) begin
            rx_q.push_back(bus.XFER_DATA);
            dest_ack <= d_sync[2];
        end
    end

    // Count completion pulses.
    always @(negedge clk) begin
        if (bus.DONE) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Wait up to max falling edges for DONE; seen = index or -1.
    task automatic wait_done(input int max, output int seen);
        seen = -1;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (bus.DONE) begin
                seen = k;
                break;
            end
        end
    endtask

    initial begin
        logic [DW-1:0] words[3];
        logic          exp_req;
        int            seen, n_done, idx_done, first_err, exp_first, base, cyc, sent;
        logic          rdy_at_done;
        logic [DW-1:0] w;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.READY_OUT, 1);
        chk("rst_req", bus.XFER_REQ, 0);
        chk("rst_data", bus.XFER_DATA, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_terr", bus.TIMEOUT_ERR, 0);

        // ---------------- single word, ack 5 cycles later ----------------
        data_in = 32'hDEADBEEF; valid_in = 1'b1;
        @(posedge clk); #1;
        chk("t1_req", bus.XFER_REQ, 1);
        chk("t1_data", bus.XFER_DATA, 32'hDEADBEEF);
        chk("t1_ready_low", bus.READY_OUT, 0);
        @(negedge clk);
        valid_in = 1'b0; data_in = $urandom;
        repeat (4) begin
            @(negedge clk);
            chk("t1_hold", {bus.DONE, bus.XFER_REQ, bus.XFER_DATA}, {1'b0, 1'b1, 32'hDEADBEEF});
        end
        man_ack = 1'b1;
        n_done = 0; idx_done = -1; rdy_at_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.DONE) begin
                n_done++; idx_done = k; rdy_at_done = bus.READY_OUT;
            end
            if (!bus.READY_OUT) chk("t1_hold2", bus.XFER_DATA, 32'hDEADBEEF);
        end
        chk("t1_done_count", n_done, 1);
        chk("t1_done_latency", idx_done, 3);
        chk("t1_ready_with_done", rdy_at_done, 1);

        // ---------------- reset in WAIT_ACK ----------------
        data_in = 32'h5A5A5A5A; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("t4_in_wait", bus.READY_OUT, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t4_async_req", bus.XFER_REQ, 0);
        chk("t4_async_data", bus.XFER_DATA, 0);
        chk("t4_async_ready", bus.READY_OUT, 1);
        chk("t4_async_done", bus.DONE, 0);
        @(negedge clk) man_ack = 1'b1;
        @(negedge clk) man_ack = 1'b0;
        @(negedge clk) rst = 1'b0;
        base = done_cnt;
        repeat (6) begin
            @(negedge clk);
            chk("t4_idle", {bus.READY_OUT, bus.XFER_REQ, bus.DONE}, 3'b100);
        end
        chk("t4_no_done", done_cnt - base, 0);

        // ---------------- VALID held high, three words ----------------
        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
        exp_req = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = words[i];
            @(posedge clk); #1;
            exp_req = ~exp_req;
            chk("t3_req", bus.XFER_REQ, exp_req);
            chk("t3_data", bus.XFER_DATA, words[i]);
            data_in = 32'hBAD00000 | i;
            repeat (4) begin
                @(negedge clk);
                chk("t3_hold", {bus.READY_OUT, bus.XFER_REQ, bus.XFER_DATA}, {1'b0, exp_req, words[i]});
            end
            man_ack = exp_req;
            wait_done(10, seen);
            chk("t3_done_seen", (seen >= 0), 1);
            chk("t3_data_at_done", bus.XFER_DATA, words[i]);
        end
        valid_in = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t3_no_extra", {bus.READY_OUT, bus.XFER_REQ, bus.XFER_DATA}, {1'b1, 1'b1, 32'h3});
        end

        // ---------------- acknowledge timeout ----------------
        data_in = 32'h00C0FFEE; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        first_err = -1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (bus.TIMEOUT_ERR && first_err < 0) first_err = k;
        end
`ifdef RD_CDC_TX_TIMEOUT_EN
        exp_first = TO;
`else
        exp_first = -1;
`endif
        chk("t5_timeout_cycle", first_err, exp_first);
        chk("t5_still_waiting", {bus.READY_OUT, bus.XFER_DATA}, {1'b0, 32'h00C0FFEE});
        @(negedge clk);
        man_ack = 1'b0;
        wait_done(10, seen);
        chk("t5_late_done", (seen >= 0), 1);
        chk("t5_terr_sticky", bus.TIMEOUT_ERR, (exp_first > 0));

        // ---------------- random words via asynchronous destination ----------------
        repeat (12) @(negedge clk);
        auto_ack = 1'b1;
        base = done_cnt;
        sent = 0; cyc = 0;
        while (sent < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (bus.READY_OUT) begin
                if ($urandom_range(3, 0) != 0) begin
                    w = $urandom;
                    data_in = w; valid_in = 1'b1;
                    sent_q.push_back(w);
                    sent++;
                end else begin
                    valid_in = 1'b0; data_in = $urandom;
                end
            end else begin
                valid_in = 1'($urandom_range(1, 0)); data_in = $urandom;
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        cyc = 0;
        while ((rx_q.size() < sent_q.size() || !bus.READY_OUT) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk("rand_sent", sent_q.size(), 1000);
        chk("rand_received", rx_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
            chk("rand_word", rx_q[i], sent_q[i]);
        end
        chk("rand_done_count", done_cnt - base, sent_q.size());
        chk("rand_idle", bus.READY_OUT, 1);
        chk("rand_terr", bus.TIMEOUT_ERR, (exp_first > 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rd_cdc_tx

// File: doc/rd_cdc_tx.md
# rd_cdc_tx

Source-domain side of a four-phase-free toggle handshake that moves one multi-bit word into another clock domain. Captures a word on a valid/ready handshake, holds it stable on `XFER_DATA`, and toggles `XFER_REQ`. The destination samples `XFER_REQ` through a 3-stage synchronizer and returns a toggle on `XFER_ACK_ASYNC`. This block re-synchronizes that acknowledge and then frees itself for the next word. It sits between the readout control logic and any slower or unrelated clock domain in the readout path.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of transferred word.
- `SYNC_STAGES`, 3: flops in the ack synchronizer; must be ≥3.
- `TIMEOUT_CYCLES`, 1024: ack timeout; used only with `RD_CDC_TX_TIMEOUT_EN`.

Ports:
- `CLK` in 1: source-domain clock; the only clock.
- `RST` in 1: asynchronous, active-high reset.
- `DATA_IN` in DATA_WIDTH: word to send.
- `VALID_IN` in 1: `DATA_IN` valid.
- `READY_OUT` out 1: block can accept a word.
- `XFER_DATA` out DATA_WIDTH: registered word, stable while a transfer is pending.
- `XFER_REQ` out 1: request toggle, registered, no glitches.
- `XFER_ACK_ASYNC` in 1: acknowledge toggle from the destination domain (asynchronous).
- `DONE` out 1: one-cycle pulse when a transfer completes.
- `TIMEOUT_ERR` out 1: sticky timeout flag; tied to 0 without the macro.

## Operation
- State machine: IDLE, WAIT_ACK.
- Reset values: state IDLE, `XFER_REQ`=0, `XFER_DATA`=0, ack synchronizer all 0, `READY_OUT`=1, `DONE`=0, `TIMEOUT_ERR`=0.
- `READY_OUT` = (state == IDLE). It is combinational from the state register only, never from `VALID_IN`.
- IDLE: on an edge with `VALID_IN`&&`READY_OUT`:
  - `XFER_DATA` <= `DATA_IN`
  - `XFER_REQ` <= ~`XFER_REQ`
  - go to WAIT_ACK
- WAIT_ACK:
  - `XFER_DATA` and `XFER_REQ` are held. `VALID_IN` is ignored.
  - When `ack_sync` == `XFER_REQ`: go to IDLE and pulse `DONE` for that one cycle.
- `ack_sync` is the last stage of the `SYNC_STAGES`-deep synchronizer on `XFER_ACK_ASYNC`.
- Completion is level-compare (equality of toggles), not edge detect. A missed intermediate value therefore cannot deadlock the block.
- `XFER_DATA` changes only on the same edge that toggles `XFER_REQ`. The destination must sample data only after it sees the req toggle.
- Reset mid-transfer:
  - Returns the block to IDLE with req=0 immediately.
  - The destination domain must be reset in the same event. The toggle parity otherwise mismatches, which is a system rule and is not detected here.

## Timing
- Capture edge T0: `XFER_REQ`/`XFER_DATA` update at T0. `READY_OUT` goes low after T0.
- Ack toggle arriving before edge Ta: `ack_sync` reflects it after Ta+SYNC_STAGES-1.
  - State returns to IDLE and `DONE` is high in the following cycle.
  - `READY_OUT` goes high in that same cycle.
- Back-to-back: a new word can be captured on the first edge where `READY_OUT`=1. There is no extra bubble.
- Minimum round trip in source cycles: 1 + SYNC_STAGES + destination latency.

## Configuration
- `RD_CDC_TX_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT_ACK and increments each cycle in WAIT_ACK.
  - When the counter reaches `TIMEOUT_CYCLES`-1, `TIMEOUT_ERR` is set. It stays set until `RST`.
  - The counter saturates. State remains WAIT_ACK, so no data is dropped.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter exists and `TIMEOUT_ERR` is constant 0.

## Structure
- Shared package `rd_cdc_pkg`:
  - state enum (IDLE, WAIT_ACK)
  - `RD_CDC_MIN_SYNC_STAGES`=3
- Sub-module `rd_sync_ar`:
  - 1-bit `SYNC_STAGES` synchronizer with async active-high reset to 0.
  - ASYNC_REG="TRUE" and SHREG_EXTRACT="NO" on its register.
  - Instantiated once for `XFER_ACK_ASYNC`.
- Elaboration error if `SYNC_STAGES` < 3.

## Test plan
- Reset release → `READY_OUT`=1, `XFER_REQ`=0, `XFER_DATA`=0, `DONE`=0, `TIMEOUT_ERR`=0.
- `DATA_IN`=0xDEADBEEF with `VALID_IN` for 1 cycle; bench returns ack toggle 5 cycles later → `XFER_REQ`=1, `XFER_DATA`=0xDEADBEEF until done. `DONE` pulses exactly once, 3 cycles after the ack toggle edge, and `READY_OUT` rises with it.
- `VALID_IN` held high with 0x1, 0x2, 0x3 → exactly three transfers. Req toggles 0→1→0→1 and each `XFER_DATA` stays stable until its matching ack. Words offered while `READY_OUT`=0 are not captured.
- Ack held constant, macro on, `TIMEOUT_CYCLES`=16 → `TIMEOUT_ERR` rises 16 cycles after capture and stays set. A late ack toggle still yields `DONE` and IDLE, and `TIMEOUT_ERR` remains 1.
- `RST` asserted in WAIT_ACK with ack toggled during reset → outputs go to reset values asynchronously. After release the block is in IDLE with no spurious `DONE`.
- Ack driven asynchronously from a 37 MHz bench clock against a 100 MHz `CLK`, 1000 random words → destination scoreboard matches all words in order, no hang.
